// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    modport master (output w_en, r_en, data_in, input data_out, full, empty);
    modport slave  (input w_en, r_en, data_in, output data_out, full, empty);
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: dual-port register array, synchronous write, registered read.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // only the read register is reset; storage keeps stale contents
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and registered read data.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]           wptr, rptr;
    logic                  full, empty, wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rdata;
    // flags depend only on registered pointers
    assign empty = wptr == rptr;
    assign full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign wr_acc = bus.w_en && !full && !rst;
    assign rd_acc = bus.r_en && !empty && !rst;
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.data_out = rdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wr_acc ? wptr + (AW+1)'(1) : wptr;
            rptr <= rd_acc ? rptr + (AW+1)'(1) : rptr;
        end
    end
    sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_acc),
        .waddr(wptr[AW-1:0]),
        .wdata(bus.data_in),
        .re   (rd_acc),
        .raddr(rptr[AW-1:0]),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus with a queue-based scoreboard monitor.
module tb_sync_fifo;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] q [$];
    logic [7:0] last = '0;
    sync_fifo_if #(.DATA_WIDTH(8)) bus ();
    sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic s_rst, input logic w, input logic r, input logic [7:0] d);
        rst = s_rst;
        bus.w_en = w;
        bus.r_en = r;
        bus.data_in = d;
        @(negedge clk);
    endtask
    // scoreboard: accepts/drops modelled from queue occupancy before the edge
    initial begin
        logic wacc, racc;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                last = '0;
            end else begin
                wacc = bus.w_en && (q.size() < DEPTH);
                racc = bus.r_en && (q.size() > 0);
                if (racc) last = q.pop_front();
                if (wacc) q.push_back(bus.data_in);
            end
            @(negedge clk);
            check("sb_data_out", 32'(bus.data_out), 32'(last));
            check("sb_empty", 32'(bus.empty), 32'(q.size() == 0));
            check("sb_full", 32'(bus.full), 32'(q.size() == DEPTH));
        end
    end
    initial begin
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        bus.data_in = '0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 8'h00);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_data", 32'(bus.data_out), 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i));
        check("fill_full", 32'(bus.full), 1);
        step(0, 1, 0, 8'hFF);
        check("ovf_full", 32'(bus.full), 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 8'h00);
            check("drain_data", 32'(bus.data_out), i);
        end
        check("drain_empty", 32'(bus.empty), 1);
        step(0, 0, 1, 8'h00);
        check("udf_hold", 32'(bus.data_out), 8'h08);
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 40; c++)
                step(0, (c < 30) && (c % 2 == 0), (c >= 10) && (c % 2 == 0), 8'($urandom));
        check("alt_empty", 32'(bus.empty), 1);
        step(0, 1, 0, 8'h11);
        step(0, 1, 0, 8'h22);
        step(0, 1, 0, 8'h33);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 8'h40 + 8'(i));
            check("sim_data", 32'(bus.data_out), (i < 3) ? 32'h11 * (i + 1) : 32'h40 + i - 3);
            check("sim_not_full", 32'(bus.full), 0);
            check("sim_not_empty", 32'(bus.empty), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'h00);
            check("sim_tail", 32'(bus.data_out), 32'h42 + i);
        end
        check("sim_empty", 32'(bus.empty), 1);
        step(0, 1, 1, 8'h5A);
        check("both_empty_flag", 32'(bus.empty), 0);
        check("both_empty_data", 32'(bus.data_out), 8'h44);
        step(0, 0, 1, 8'h00);
        check("both_empty_read", 32'(bus.data_out), 8'h5A);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'h80 + 8'(i));
        check("full_again", 32'(bus.full), 1);
        step(0, 1, 1, 8'hEE);
        check("both_full_flag", 32'(bus.full), 0);
        check("both_full_data", 32'(bus.data_out), 8'h81);
        for (int i = 2; i <= 8; i++) begin
            step(0, 0, 1, 8'h00);
            check("both_full_rest", 32'(bus.data_out), 32'h80 + i);
        end
        check("both_full_empty", 32'(bus.empty), 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h60 + 8'(i));
        step(1, 0, 0, 8'h00);
        check("mid_rst_empty", 32'(bus.empty), 1);
        check("mid_rst_data", 32'(bus.data_out), 0);
        step(0, 1, 0, 8'hA5);
        step(0, 0, 1, 8'h00);
        check("mid_rst_read", 32'(bus.data_out), 8'hA5);
        check("mid_rst_final_empty", 32'(bus.empty), 1);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
